// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module : prog_loader_pkg
// Brief  : Shared CPU constants, instruction field layout and loader FSM states.
// Rev    : 1.0  initial release
// ============================================================================
package prog_loader_pkg;

    localparam int INST_W        = 16;
    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_MAX_WORDS = 1 << DEF_ADDR_W;

    // Instruction word layout: {opcode, srcadd_1, srcadd_2, dstadd}
    localparam int OPC_LSB  = 12;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_LSB = 4;
    localparam int DST_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_CHK  = 3'd4
    } ld_state_t;

    function automatic logic [INST_W-1:0] pack_inst(input logic [7:0] hi, input logic [7:0] lo);
        logic [INST_W-1:0] w;
        w                 = '0;
        w[OPC_LSB  +: 4]  = hi[7:4];
        w[SRC1_LSB +: 4]  = hi[3:0];
        w[SRC2_LSB +: 4]  = lo[7:4];
        w[DST_LSB  +: 4]  = lo[3:0];
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module : prog_loader
// Brief  : Byte-stream program loader: length, N instruction words, checksum.
// Rev    : 1.0  initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [INST_W-1:0] mem_wdata,
    output logic              stop,
    output logic              done,
    output logic              error
);

    localparam int                 c_len_w   = ADDR_W + 1;
    localparam logic [8:0]         c_max_len = 9'(MAX_WORDS);
    localparam logic [c_len_w-1:0] c_len_one = c_len_w'(1);

    ld_state_t           r_state;
    ld_state_t           w_next;
    logic [c_len_w-1:0]  r_len;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_hi;
    logic [7:0]          r_chk;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [INST_W-1:0]   r_mem_wdata;
    logic                r_done;
    logic                r_error;

    logic w_accept;
    logic w_upd;
    logic w_len_bad;
    logic w_last;
    logic w_write;
    logic w_set_done;
    logic w_set_err;
    logic w_clr;

    assign byte_ready = (r_state != ST_IDLE);
    assign stop       = (r_state != ST_IDLE);
    assign w_accept   = byte_valid & byte_ready;
    assign w_upd      = w_accept & ~abort;
    assign w_len_bad  = (byte_data == 8'd0) || ({1'b0, byte_data} > c_max_len);
    assign w_last     = ({1'b0, r_addr} == (r_len - c_len_one));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_write    = 1'b0;
        w_set_done = 1'b0;
        w_set_err  = 1'b0;
        w_clr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_LEN;
                    w_clr  = 1'b1;
                end
            end
            ST_LEN: begin
                if (w_accept) begin
                    w_next    = w_len_bad ? ST_IDLE : ST_HI;
                    w_set_err = w_len_bad;
                end
            end
            ST_HI: begin
                if (w_accept) w_next = ST_LO;
            end
            ST_LO: begin
                if (w_accept) begin
                    w_write = 1'b1;
                    w_next  = w_last ? ST_CHK : ST_HI;
                end
            end
            ST_CHK: begin
                if (w_accept) begin
                    w_next     = ST_IDLE;
                    w_set_done = (byte_data == r_chk);
                    w_set_err  = (byte_data != r_chk);
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // Abort overrides everything except a write already captured this cycle.
        if (abort && (r_state != ST_IDLE)) begin
            w_next     = ST_IDLE;
            w_set_done = 1'b0;
            w_set_err  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len       <= '0;
            r_addr      <= '0;
            r_hi        <= '0;
            r_chk       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_mem_we <= w_write;
            if (w_write) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= pack_inst(r_hi, byte_data);
            end
            if (w_clr) begin
                r_done  <= 1'b0;
                r_error <= 1'b0;
            end
            if (w_set_done) r_done  <= 1'b1;
            if (w_set_err)  r_error <= 1'b1;
            if (w_upd) begin
                case (r_state)
                    ST_LEN: begin
                        if (!w_len_bad) begin
                            r_len  <= byte_data[c_len_w-1:0];
                            r_addr <= '0;
                            r_chk  <= byte_data;
                        end
                    end
                    ST_HI: begin
                        r_hi  <= byte_data;
                        r_chk <= r_chk ^ byte_data;
                    end
                    ST_LO: begin
                        r_chk <= r_chk ^ byte_data;
                        // Last word holds the counter so it never wraps inside a load.
                        if (!w_last) r_addr <= r_addr + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign done      = r_done;
    assign error     = r_error;

endmodule
`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 4, instruction-memory address width (program counter width).
REQ-002 Parameter MAX_WORDS, default 16, maximum instructions per load; SHALL equal 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (port name as elsewhere in the CPU; polarity/synchronicity fixed).
REQ-005 start  input  1  begin a program load; honoured only in IDLE.
REQ-006 abort  input  1  synchronous abort of a load in progress.
REQ-007 byte_valid  input  1  host byte-stream valid.
REQ-008 byte_data  input  8  host byte-stream data.
REQ-009 byte_ready  output  1  loader can accept a byte this cycle.
REQ-010 mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-011 mem_addr  output  ADDR_W  write address.
REQ-012 mem_wdata  output  16  instruction word {opcode[15:12], srcadd_1[11:8], srcadd_2[7:4], dstadd[3:0]}.
REQ-013 stop  output  1  holds fetch/PC while a load is in progress.
REQ-014 done  output  1  sticky: last load completed with good checksum.
REQ-015 error  output  1  sticky: last load failed (bad length, bad checksum, abort).

Function
REQ-016 The stream format SHALL be: length byte N, then N instructions as high byte then low byte, then a checksum byte.
REQ-017 A byte SHALL be accepted only in a cycle where byte_valid and byte_ready are both 1.
REQ-018 The FSM SHALL have the states IDLE, LEN, HI, LO, CHK; byte_ready SHALL be 1 exactly in LEN, HI, LO and CHK.
REQ-019 IDLE: start=1 -> LEN next cycle; done and error are cleared on the same edge; start outside IDLE is ignored.
REQ-020 LEN: accepted byte N with N==0 or N>MAX_WORDS -> error=1, IDLE; otherwise latch N, clear address counter, chk=N, -> HI.
REQ-021 HI: accepted byte latched as high byte, chk^=byte, -> LO.
REQ-022 LO: on acceptance, mem_we=1 on the following cycle only, with mem_addr=current address and mem_wdata={high,low}; chk^=byte; address increments.
REQ-023 LO exit: if the word just written was word N-1 -> CHK, else -> HI; the address counter SHALL NOT wrap within a load.
REQ-024 CHK: accepted byte equal to chk -> done=1; otherwise -> error=1; either way -> IDLE.
REQ-025 stop SHALL be 1 in every non-IDLE state and 0 in IDLE, so stop rises the cycle after start and falls the cycle after the checksum byte is accepted.
REQ-026 abort=1 in any non-IDLE state -> IDLE next cycle with error=1 and no further mem_we; a pending mem_we from a LO acceptance in the same cycle SHALL still issue; abort in IDLE is ignored.
REQ-027 When start and abort are both 1 in IDLE, start wins.
REQ-028 When byte_valid=0, state, counters and chk SHALL hold (stall of any length).
REQ-029 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-030 reset low SHALL asynchronously force IDLE and byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, stop=0, done=0, error=0, chk=0, counters=0.
REQ-031 reset low mid-load SHALL abandon the load without setting error; already-written words are not retracted.

Structure
REQ-032 INST_W=16, ADDR_W, MAX_WORDS, the instruction field bit positions and the FSM state encoding SHALL live in the shared CPU package.
REQ-033 prog_loader SHALL be a single module with no sub-modules; it drives the InstMem write port, and its stop is ORed with the external stop at the top level.

Verification
REQ-034 Load N=1: bytes 01,12,34,27 -> single mem_we with addr 0, wdata 0x1234; done=1, error=0; stop high for exactly 4 accept cycles +1.
REQ-035 Load N=16 with wdata=addr*0x1111 and correct checksum -> 16 writes, addr 0..15 in order, no wrap, done=1.
REQ-036 Length 00, then a separate load with length 11 (17) -> error=1, no mem_we, IDLE next cycle for each.
REQ-037 N=1 with bytes 01,12,34,00 -> write of 0x1234 occurs, then error=1, done=0.
REQ-038 Random byte_valid gaps plus abort asserted after the 3rd word's LO byte -> exactly 3 writes, error=1, stop low next cycle.
REQ-039 reset driven low asynchronously mid-HI -> all outputs 0 immediately; a subsequent full N=1 load completes with done=1.
